// File: rtl/mem_dma_initiator_pkg.sv
// -----------------------------------------------------------------------------
// mem_dma_initiator_pkg
//   Shared definitions for the memory DMA initiator and its neighbours:
//   - the word-address type used by the memory/MMIO responder
//   - the memory-mapped I/O word addresses (HEX, LEDR, KEY, SW)
//   - the DMA mode encoding seen on the 1-bit 'mode' input
//   - a helper for word-address increment (silently wraps modulo 2^30)
// -----------------------------------------------------------------------------
package mem_dma_initiator_pkg;

  localparam int ADDR_BIT_WIDTH = 30;

  typedef logic [ADDR_BIT_WIDTH-1:0] word_addr_t;

  // Memory-mapped I/O word addresses shared with the processor.
  localparam word_addr_t ADDR_HEX  = 30'h0000_1000;
  localparam word_addr_t ADDR_LEDR = 30'h0000_1001;
  localparam word_addr_t ADDR_KEY  = 30'h0000_1002;
  localparam word_addr_t ADDR_SW   = 30'h0000_1003;

  // Transfer mode as presented on the engine's 'mode' input.
  typedef enum logic {
    DMA_MODE_COPY = 1'b0,
    DMA_MODE_FILL = 1'b1
  } dma_mode_e;

  // Next word address; the carry out of bit 29 is dropped on purpose so that
  // 3FFFFFFF rolls over to 0.
  function automatic word_addr_t next_word_addr(input word_addr_t addr);
    return addr + word_addr_t'(1);
  endfunction

endpackage : mem_dma_initiator_pkg

// File: rtl/mem_dma_initiator_if.sv
// -----------------------------------------------------------------------------
// mem_dma_initiator_if
//   Single-port word memory bus between an initiator and the Memory/MMIO
//   responder, including the arbiter grant.
//   Signals:
//     req       initiator -> arbiter    port request
//     gnt       arbiter   -> initiator  port granted this cycle
//     addr      initiator -> memory     word address
//     en_write  initiator -> memory     write enable (only ever high with gnt)
//     wdata     initiator -> memory     write data
//     rdata     memory    -> initiator  read data, combinational from addr
//   Modports:
//     master  the DMA engine side
//     slave   the memory/arbiter side
// -----------------------------------------------------------------------------
interface mem_dma_initiator_if
  import mem_dma_initiator_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = 32
);

  logic                      req;
  logic                      gnt;
  word_addr_t                addr;
  logic                      en_write;
  logic [DATA_BIT_WIDTH-1:0] wdata;
  logic [DATA_BIT_WIDTH-1:0] rdata;

  modport master (
    output req,
    output addr,
    output en_write,
    output wdata,
    input  gnt,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    input  en_write,
    input  wdata,
    output gnt,
    output rdata
  );

endinterface : mem_dma_initiator_if

// File: rtl/mem_dma_initiator.sv
// -----------------------------------------------------------------------------
// mem_dma_initiator
//   Bus initiator that copies a block of words (src -> dst) or fills a block
//   with a constant, sharing the memory port with the processor through an
//   external arbiter. While the grant is low the engine holds every register,
//   so a stalled transfer resumes exactly where it stopped.
//
//   Ports:
//     clk         in   system clock
//     reset       in   synchronous, active-high reset (aborts any transfer)
//     start       in   1-cycle request, only looked at while idle
//     mode        in   0 = copy src->dst, 1 = fill dst with fill_value
//     src_addr    in   first source word address (copy only)
//     dst_addr    in   first destination word address
//     len         in   number of words; 0 completes without touching memory
//     fill_value  in   fill word (fill only)
//     busy        out  high while reading/writing
//     done        out  1-cycle completion pulse
//     mem         master side of the memory bus interface
//
//   Timing with the grant held high, start accepted at cycle 0:
//     copy of N words -> done at cycle 2N+1 (one READ + one WRITE per word)
//     fill of N words -> done at cycle N+1
//     len == 0        -> done at cycle 1
// -----------------------------------------------------------------------------
module mem_dma_initiator
  import mem_dma_initiator_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int LEN_BIT_WIDTH  = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      mode,
  input  word_addr_t                src_addr,
  input  word_addr_t                dst_addr,
  input  logic [LEN_BIT_WIDTH-1:0]  len,
  input  logic [DATA_BIT_WIDTH-1:0] fill_value,
  output logic                      busy,
  output logic                      done,
  mem_dma_initiator_if.master       mem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef logic [LEN_BIT_WIDTH-1:0] len_t;

  state_e                    state_q;
  word_addr_t                cur_src_q;
  word_addr_t                cur_dst_q;
  len_t                      cnt_q;
  logic [DATA_BIT_WIDTH-1:0] buf_q;
  dma_mode_e                 mode_q;

  // Next-state helpers for the counters; pure arithmetic, no state.
  word_addr_t cur_src_d;
  word_addr_t cur_dst_d;
  len_t       cnt_d;

  assign cur_src_d = next_word_addr(cur_src_q);
  assign cur_dst_d = next_word_addr(cur_dst_q);
  assign cnt_d     = cnt_q - len_t'(1);

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous here, so it is tested inside the clocked block
  // and is absent from the sensitivity list; every register assigned below is
  // updated with <= so all of them see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: these are a handful of flops, not a memory array, so clearing
      // them on reset is cheap and keeps the outputs defined from cycle one.
      state_q   <= S_IDLE;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      mode_q    <= DMA_MODE_COPY;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_src_q <= src_addr;
            cur_dst_q <= dst_addr;
            cnt_q     <= len;
            // Preloading the fill word means a fill never needs a READ; a copy
            // overwrites it on its first read.
            buf_q     <= fill_value;
            mode_q    <= dma_mode_e'(mode);
            if (len == '0) begin
              state_q <= S_DONE;
            end else if (dma_mode_e'(mode) == DMA_MODE_FILL) begin
              state_q <= S_WRITE;
            end else begin
              state_q <= S_READ;
            end
          end
        end

        S_READ: begin
          if (mem.gnt) begin
            buf_q     <= mem.rdata;
            cur_src_q <= cur_src_d;
            state_q   <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (mem.gnt) begin
            cur_dst_q <= cur_dst_d;
            cnt_q     <= cnt_d;
            // cnt_q still holds the count including the word being written.
            if (cnt_q == len_t'(1)) begin
              state_q <= S_DONE;
            end else if (mode_q == DMA_MODE_FILL) begin
              state_q <= S_WRITE;
            end else begin
              state_q <= S_READ;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bus drive: decoded straight from the state and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case, so no path through the
  // block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mem.req      = 1'b0;
    mem.addr     = '0;
    mem.en_write = 1'b0;
    mem.wdata    = '0;
    case (state_q)
      S_READ: begin
        mem.req  = 1'b1;
        mem.addr = cur_src_q;
      end
      S_WRITE: begin
        mem.req      = 1'b1;
        mem.addr     = cur_dst_q;
        mem.wdata    = buf_q;
        // Gating with the grant guarantees no write lands while another
        // initiator owns the port.
        mem.en_write = mem.gnt;
      end
      default: begin
      end
    endcase
  end

  assign busy = (state_q == S_READ) || (state_q == S_WRITE);
  assign done = (state_q == S_DONE);

endmodule : mem_dma_initiator

// File: tb/tb_mem_dma_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_dma_initiator
//   Self-checking bench for mem_dma_initiator. A 1024-word memory with an LEDR
//   register sits on the slave side of the interface; a behavioural model
//   predicts memory contents, completion cycle and write/request counts.
// -----------------------------------------------------------------------------
module tb_mem_dma_initiator;
  import mem_dma_initiator_pkg::*;

  localparam int DW        = 32;
  localparam int LW        = 12;
  localparam int MEM_WORDS = 1024;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             mode;
  word_addr_t       src_addr;
  word_addr_t       dst_addr;
  logic [LW-1:0]    len;
  logic [DW-1:0]    fill_value;
  logic             busy;
  logic             done;
  logic             gnt;

  mem_dma_initiator_if #(.DATA_BIT_WIDTH(DW)) mem_bus ();

  mem_dma_initiator #(
    .DATA_BIT_WIDTH(DW),
    .LEN_BIT_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .fill_value(fill_value),
    .busy      (busy),
    .done      (done),
    .mem       (mem_bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Memory / MMIO responder model
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [MEM_WORDS];
  logic [9:0]    mmio_ledr_out;
  logic          tb_clr;
  int            wr_cnt;
  int            req_cnt;
  int            viol_cnt = 0;

  function automatic logic [DW-1:0] pattern(input int unsigned a);
    return 32'hA500_0000 | DW'(a);
  endfunction

  assign mem_bus.gnt   = gnt;
  assign mem_bus.rdata = (mem_bus.addr == ADDR_LEDR) ? {22'b0, mmio_ledr_out}
                                                     : mem[mem_bus.addr[9:0]];

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= pattern(i);
      mmio_ledr_out <= '0;
      wr_cnt        <= 0;
      req_cnt       <= 0;
    end else begin
      if (mem_bus.req) req_cnt <= req_cnt + 1;
      if (mem_bus.en_write) begin
        wr_cnt <= wr_cnt + 1;
        if (mem_bus.addr == ADDR_LEDR) mmio_ledr_out <= mem_bus.wdata[9:0];
        else                           mem[mem_bus.addr[9:0]] <= mem_bus.wdata;
      end
    end
    if (mem_bus.en_write && !gnt) viol_cnt <= viol_cnt + 1;
  end

  // ---------------------------------------------------------------------------
  // Expected-state model
  // ---------------------------------------------------------------------------
  logic [DW-1:0] exp_mem [MEM_WORDS];
  logic [9:0]    exp_ledr;

  task automatic model_run(input logic m, input word_addr_t s, input word_addr_t d,
                           input int n, input logic [DW-1:0] f);
    word_addr_t    sa, da;
    logic [DW-1:0] v;
    for (int i = 0; i < MEM_WORDS; i++) exp_mem[i] = pattern(i);
    exp_ledr = '0;
    for (int i = 0; i < n; i++) begin
      sa = s + word_addr_t'(i);
      da = d + word_addr_t'(i);
      if (m) v = f;
      else if (sa == ADDR_LEDR) v = {22'b0, exp_ledr};
      else v = exp_mem[sa[9:0]];
      if (da == ADDR_LEDR) exp_ledr = v[9:0];
      else exp_mem[da[9:0]] = v;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== exp_mem[i]) bad++;
    check({name, "_mem_mismatches"}, 64'(bad), 64'd0);
    check({name, "_ledr"}, 64'(mmio_ledr_out), 64'(exp_ledr));
  endtask

  task automatic init_mem();
    @(posedge clk); #1 tb_clr = 1'b1;
    @(posedge clk); #1 tb_clr = 1'b0;
  endtask

  // Leaves the bench #1 into cycle 1 (the edge ending cycle 0 samples start).
  task automatic do_start(input logic m, input word_addr_t s, input word_addr_t d,
                          input int n, input logic [DW-1:0] f);
    @(posedge clk); #1;
    mode = m; src_addr = s; dst_addr = d; len = LW'(n); fill_value = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the cycle index in which done was seen, or -1 on timeout.
  task automatic wait_done(input int first_cyc, output int done_cyc);
    int cyc = first_cyc;
    done_cyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string         name;
    logic          mode;
    word_addr_t    src;
    word_addr_t    dst;
    int            len;
    logic [DW-1:0] fill;
    int            exp_done;
    int            exp_wr;
    int            exp_req;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int dc;
    int bad;
    int pulses;

    vecs[0] = '{"copy4",     1'b0, 30'h10,        30'h40,        4, 32'h0,         9, 4, 8};
    vecs[1] = '{"fill3",     1'b1, 30'h0,         30'h100,       3, 32'hDEADBEEF,  4, 3, 3};
    vecs[2] = '{"len0",      1'b0, 30'h10,        30'h40,        0, 32'h0,         1, 0, 0};
    vecs[3] = '{"fill_ledr", 1'b1, 30'h0,         ADDR_LEDR,     1, 32'h2AA,       2, 1, 1};
    vecs[4] = '{"overlap",   1'b0, 30'h20,        30'h21,        3, 32'h0,         7, 3, 6};
    vecs[5] = '{"wrap_fill", 1'b1, 30'h0,         30'h3FFFFFFE,  4, 32'h55,        5, 4, 4};
    vecs[6] = '{"wrap_copy", 1'b0, 30'h3FFFFFFF,  30'h80,        2, 32'h0,         5, 2, 4};

    reset = 1'b1; tb_clr = 1'b1; start = 1'b0; mode = 1'b0; gnt = 1'b1;
    src_addr = '0; dst_addr = '0; len = '0; fill_value = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; tb_clr = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy",     64'(busy),              64'd0);
    check("rst_done",     64'(done),              64'd0);
    check("rst_req",      64'(mem_bus.req),       64'd0);
    check("rst_en_write", 64'(mem_bus.en_write),  64'd0);
    check("rst_addr",     64'(mem_bus.addr),      64'd0);
    check("rst_wdata",    64'(mem_bus.wdata),     64'd0);

    // Table-driven transfers with the grant held high
    foreach (vecs[i]) begin
      init_mem();
      model_run(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill);
      do_start(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill);
      wait_done(1, dc);
      check({vecs[i].name, "_done_cycle"}, 64'(dc),      64'(vecs[i].exp_done));
      check({vecs[i].name, "_busy_in_done"}, 64'(busy),  64'd0);
      check({vecs[i].name, "_writes"},     64'(wr_cnt),  64'(vecs[i].exp_wr));
      check({vecs[i].name, "_reqs"},       64'(req_cnt), 64'(vecs[i].exp_req));
      check_mem(vecs[i].name);
      @(posedge clk); #1;
      @(negedge clk);
      check({vecs[i].name, "_done_one_cycle"}, 64'(done), 64'd0);
    end

    // Grant stall: copy of 2 words, grant low for 5 cycles in the first WRITE
    init_mem();
    model_run(1'b0, 30'h10, 30'h40, 2, 32'h0);
    do_start(1'b0, 30'h10, 30'h40, 2, 32'h0);
    @(negedge clk);
    check("stall_busy_c1", 64'(busy), 64'd1);
    @(posedge clk); #1 gnt = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_bus.en_write !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("stall_no_en_write", 64'(bad),           64'd0);
    check("stall_no_writes",   64'(wr_cnt),        64'd0);
    check("stall_addr_held",   64'(mem_bus.addr),  64'h40);
    check("stall_wdata_held",  64'(mem_bus.wdata), 64'(pattern(32'h10)));
    gnt = 1'b1;
    wait_done(7, dc);
    check("stall_done_cycle", 64'(dc),     64'd10);
    check("stall_writes",     64'(wr_cnt), 64'd2);
    check_mem("stall");

    // start while busy is ignored
    init_mem();
    model_run(1'b0, 30'h10, 30'h40, 2, 32'h0);
    do_start(1'b0, 30'h10, 30'h40, 2, 32'h0);
    mode = 1'b1; dst_addr = 30'h300; len = LW'(5); fill_value = 32'h1234_5678;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(2, dc);
    check("ign_done_cycle", 64'(dc),     64'd5);
    check("ign_writes",     64'(wr_cnt), 64'd2);
    check_mem("ign");

    // Reset in cycle 3 of a 4-word copy
    init_mem();
    model_run(1'b0, 30'h10, 30'h40, 1, 32'h0);
    do_start(1'b0, 30'h10, 30'h40, 4, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rmid_busy", 64'(busy),        64'd0);
    check("rmid_req",  64'(mem_bus.req), 64'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("rmid_no_done", 64'(pulses), 64'd0);
    check_mem("rmid");

    init_mem();
    model_run(1'b1, 30'h0, 30'h300, 1, 32'h0000_1234);
    do_start(1'b1, 30'h0, 30'h300, 1, 32'h0000_1234);
    wait_done(1, dc);
    check("rmid_restart_done", 64'(dc), 64'd2);
    check_mem("rmid_restart");

    check("no_write_without_gnt", 64'(viol_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_dma_initiator
